// File: rtl/glitch_sequencer.sv
// Clock-glitch sequencer: after arm and a trigger rise, drives the glitch mux
// enable/mode through a delay, then a train of width/gap-separated pulses.
module glitch_sequencer #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [WIDTH_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic [7:0]         cfg_mode,
  input  logic               arm,
  input  logic               trigger,
  input  logic               abort,
  output logic               gl_en,
  output logic [7:0]         gl_mode,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] glitch_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP, S_DONE
  } state_t;

  state_t             state;
  logic               trigger_q;
  logic [DELAY_W-1:0] lat_delay, dcnt;
  logic [WIDTH_W-1:0] lat_width, lat_gap, wcnt;
  logic [COUNT_W-1:0] lat_count;
  logic [7:0]         lat_mode;
  logic               rise;

  // trigger_q tracks in every state, so a level already high on entry to ARMED
  // never looks like a rise.
  assign rise  = trigger & ~trigger_q;
  assign armed = (state == S_ARMED);
  assign busy  = (state == S_DELAY) || (state == S_GLITCH) || (state == S_GAP);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      trigger_q  <= 1'b0;
      lat_delay  <= '0;
      lat_width  <= '0;
      lat_gap    <= '0;
      lat_count  <= '0;
      lat_mode   <= '0;
      dcnt       <= '0;
      wcnt       <= '0;
      gl_en      <= 1'b0;
      gl_mode    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      glitch_idx <= '0;
    end else begin
      trigger_q <= trigger;
      done      <= 1'b0;
      err       <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        gl_en   <= 1'b0;
        gl_mode <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              if (cfg_mode[3:0] != 4'h0) begin
                lat_delay  <= cfg_delay;
                lat_width  <= (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
                lat_gap    <= (cfg_gap   == '0) ? WIDTH_W'(1) : cfg_gap;
                lat_count  <= (cfg_count == '0) ? COUNT_W'(1) : cfg_count;
                lat_mode   <= cfg_mode;
                glitch_idx <= '0;
                state      <= S_ARMED;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_ARMED: begin
            if (rise) begin
              dcnt  <= lat_delay;
              state <= S_DELAY;
            end
          end
          // Counters load length-1 and leave on zero, so field maxima run exactly.
          S_DELAY: begin
            if (dcnt == '0) begin
              state   <= S_GLITCH;
              gl_en   <= 1'b1;
              gl_mode <= lat_mode;
              wcnt    <= lat_width - WIDTH_W'(1);
            end else begin
              dcnt <= dcnt - DELAY_W'(1);
            end
          end
          S_GLITCH: begin
            if (wcnt == '0) begin
              gl_en   <= 1'b0;
              gl_mode <= '0;
              if (glitch_idx != lat_count - COUNT_W'(1)) begin
                wcnt  <= lat_gap - WIDTH_W'(1);
                state <= S_GAP;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              wcnt <= wcnt - WIDTH_W'(1);
            end
          end
          S_GAP: begin
            if (wcnt == '0) begin
              state      <= S_GLITCH;
              gl_en      <= 1'b1;
              gl_mode    <= lat_mode;
              wcnt       <= lat_width - WIDTH_W'(1);
              glitch_idx <= glitch_idx + COUNT_W'(1);
            end else begin
              wcnt <= wcnt - WIDTH_W'(1);
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: a timeline model pushes expected
// per-cycle outputs at trigger time; each test pops and compares them.
module tb_glitch_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_delay;
  logic [7:0]  cfg_width, cfg_gap, cfg_count, cfg_mode;
  logic        arm, trigger, abort;
  logic        gl_en, armed, busy, done, err;
  logic [7:0]  gl_mode, glitch_idx;

  typedef struct packed {
    logic       en;
    logic [7:0] mode;
    logic       done;
    logic       busy;
    logic       armed;
    logic [7:0] idx;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  glitch_sequencer #(.DELAY_W(16), .WIDTH_W(8), .COUNT_W(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_count(cfg_count), .cfg_mode(cfg_mode),
    .arm(arm), .trigger(trigger), .abort(abort),
    .gl_en(gl_en), .gl_mode(gl_mode), .armed(armed), .busy(busy),
    .done(done), .err(err), .glitch_idx(glitch_idx)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(logic en, logic [7:0] mode, logic dn, logic bz, logic [7:0] idx);
    obs_t e;
    e.en = en; e.mode = mode; e.done = dn; e.busy = bz; e.armed = 1'b0; e.idx = idx;
    return e;
  endfunction

  // Expected outputs sampled after trigger edge T, T+1, ... through one idle cycle.
  function automatic void push_train(int d, int w, int g, int c, logic [7:0] m);
    if (w == 0) w = 1;
    if (g == 0) g = 1;
    if (c == 0) c = 1;
    for (int k = 0; k <= d; k++) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00));
    for (int i = 0; i < c; i++) begin
      for (int k = 0; k < w; k++) exp_q.push_back(mk(1'b1, m, 1'b0, 1'b1, 8'(i)));
      if (i < c - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'(i)));
    end
    exp_q.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'(c - 1)));
    exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'(c - 1)));
  endfunction

  // Arm for one edge, then scramble config so later changes must be ignored.
  task automatic arm_cfg(int d, int w, int g, int c, logic [7:0] m);
    @(negedge clk_in);
    cfg_delay = 16'(d); cfg_width = 8'(w); cfg_gap = 8'(g); cfg_count = 8'(c); cfg_mode = m;
    arm = 1'b1;
    @(negedge clk_in);
    arm = 1'b0;
    cfg_delay = 16'($urandom); cfg_width = 8'($urandom); cfg_gap = 8'($urandom);
    cfg_count = 8'($urandom); cfg_mode = 8'($urandom);
  endtask

  task automatic fire();
    @(negedge clk_in);
    trigger = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    n_checks++;
    if ({gl_en, gl_mode, armed, busy, done, err, glitch_idx} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {gl_en, gl_mode, armed, busy, done, err, glitch_idx});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      trigger = k[0];
      n_checks++;
      if ({gl_en, busy, armed} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_trigger cycle %0d: en/busy/armed=%b expected 000", k, {gl_en, busy, armed});
      end
    end
    trigger = 1'b0;
  endtask

  task automatic test_basic();
    obs_t o, e;
    arm_cfg(5, 3, 2, 2, 8'h08);
    n_checks++;
    if ({armed, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_armed: armed/busy=%b expected 10", {armed, busy});
    end
    push_train(5, 3, 2, 2, 8'h08);
    fire();
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_train k=%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_min();
    obs_t o, e;
    arm_cfg(0, 0, 0, 0, 8'h02);
    push_train(0, 0, 0, 0, 8'h02);
    fire();
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL min_train k=%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_bad_mode();
    arm_cfg(1, 1, 1, 1, 8'h10);
    n_checks++;
    if ({err, armed} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_mode_err: err/armed=%b expected 10", {err, armed});
    end
    @(negedge clk_in);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_mode_err_pulse: err=%b expected 0", err);
    end
    fire();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      n_checks++;
      if ({gl_en, busy, armed, err} !== 4'b0000) begin
        n_fail++;
        $display("FAIL bad_mode_ignore k=%0d: en/busy/armed/err=%b expected 0000", k, {gl_en, busy, armed, err});
      end
    end
  endtask

  task automatic test_abort();
    obs_t o, e;
    arm_cfg(2, 2, 4, 4, 8'h04);
    push_train(2, 2, 4, 4, 8'h04);
    fire();
    // Samples 5 and 6 are inside the first gap.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_prefix k=%0d: got %h expected %h", k, o, e);
      end
    end
    abort = 1'b1;
    exp_q.delete();
    @(negedge clk_in);
    abort = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if ({gl_en, gl_mode, done, busy, armed} !== 12'h0) begin
        n_fail++;
        $display("FAIL abort_quiet k=%0d: got %h expected 0", k, {gl_en, gl_mode, done, busy, armed});
      end
      @(negedge clk_in);
    end
    arm_cfg(2, 2, 4, 4, 8'h04);
    push_train(2, 2, 4, 4, 8'h04);
    fire();
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_rearm k=%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_trigger_held();
    obs_t o, e;
    trigger = 1'b1;
    arm_cfg(1, 2, 1, 1, 8'h01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      n_checks++;
      if ({armed, busy, gl_en} !== 3'b100) begin
        n_fail++;
        $display("FAIL held_no_rise k=%0d: armed/busy/en=%b expected 100", k, {armed, busy, gl_en});
      end
    end
    trigger = 1'b0;
    push_train(1, 2, 1, 1, 8'h01);
    fire();
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL held_train k=%0d: got %h expected %h", k, o, e);
      end
    end
    // Trigger coinciding with arm is not an edge in ARMED.
    @(negedge clk_in);
    cfg_delay = 16'd0; cfg_width = 8'd1; cfg_gap = 8'd1; cfg_count = 8'd1; cfg_mode = 8'h08;
    arm = 1'b1; trigger = 1'b1;
    @(negedge clk_in);
    arm = 1'b0; trigger = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      n_checks++;
      if ({armed, busy, gl_en} !== 3'b100) begin
        n_fail++;
        $display("FAIL arm_trig_same k=%0d: armed/busy/en=%b expected 100", k, {armed, busy, gl_en});
      end
    end
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit seen = 1'b0;
    arm_cfg(3, 20, 1, 1, 8'h08);
    fire();
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      seen = gl_en;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid_start: gl_en=0 expected 1 within 50 cycles");
    end
    rst_n = 1'b0; abort = 1'b1;
    @(negedge clk_in);
    n_checks++;
    if ({gl_en, gl_mode, armed, busy, done, err, glitch_idx} !== 21'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h expected 0", {gl_en, gl_mode, armed, busy, done, err, glitch_idx});
    end
    rst_n = 1'b1; abort = 1'b0;
  endtask

  task automatic test_max();
    obs_t o, e;
    arm_cfg(300, 255, 255, 3, 8'h09);
    push_train(300, 255, 255, 3, 8'h09);
    fire();
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL max_width k=%0d: got %h expected %h", k, o, e);
      end
    end
    arm_cfg(0, 1, 1, 255, 8'h01);
    push_train(0, 1, 1, 255, 8'h01);
    fire();
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      trigger = 1'b0;
      e = exp_q.pop_front();
      o = {gl_en, gl_mode, done, busy, armed, glitch_idx};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL max_count k=%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0; cfg_mode = '0;
    test_reset();
    test_basic();
    test_min();
    test_bad_mode();
    test_abort();
    test_trigger_held();
    test_rst_mid();
    test_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
